// File: rtl/clk_ratio_monitor_pkg.sv
// Shared types and default widths for the clock-ratio monitor.
package clk_ratio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } state_e;

    localparam int CNT_W_DEF       = 16;
    localparam int WIN_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/clk_ratio_monitor_if.sv
// Control/result bundle for clk_ratio_monitor; CLK_RATIO_DUTY_EN adds duty_tol/duty_err.
interface clk_ratio_monitor_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic [CNT_W-1:0] exp_min;
    logic [CNT_W-1:0] exp_max;
    logic             mon_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] edge_cnt;
    logic             overflow;
`ifdef CLK_RATIO_DUTY_EN
    logic [CNT_W-1:0] duty_tol;
    logic             duty_err;

    modport master (
        output start, win_len, exp_min, exp_max, mon_in, duty_tol,
        input  busy, done, pass, edge_cnt, overflow, duty_err
    );
    modport slave (
        input  start, win_len, exp_min, exp_max, mon_in, duty_tol,
        output busy, done, pass, edge_cnt, overflow, duty_err
    );
`else
    modport master (
        output start, win_len, exp_min, exp_max, mon_in,
        input  busy, done, pass, edge_cnt, overflow
    );
    modport slave (
        input  start, win_len, exp_min, exp_max, mon_in,
        output busy, done, pass, edge_cnt, overflow
    );
`endif
endinterface

// File: rtl/clk_ratio_edge_det.sv
// Synchronises the asynchronous monitored signal and flags its rising edges.
// level_o exists only when CLK_RATIO_DUTY_EN is defined.
module clk_ratio_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mon_i,
`ifdef CLK_RATIO_DUTY_EN
    output logic level_o,
`endif
    output logic rise_o
);
    // Fewer than two stages would not be a safe synchroniser.
    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [NSYNC-1:0] sync_q;
    logic             prev_q;
    logic             cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[NSYNC-2:0], mon_i};
            prev_q <= sync_q[NSYNC-1];
        end
    end

    assign cur    = sync_q[NSYNC-1];
    assign rise_o = cur & ~prev_q;
`ifdef CLK_RATIO_DUTY_EN
    assign level_o = cur;
`endif

endmodule

// File: rtl/clk_ratio_monitor.sv
// Counts rising edges of mon_in over a window of clk cycles and checks them against a range.
// Optional duty-cycle check enabled by defining CLK_RATIO_DUTY_EN.
module clk_ratio_monitor
    import clk_ratio_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input logic               clk,
    input logic               rst_n,
    clk_ratio_monitor_if.slave bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic in_range(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (lo <= hi) && (v >= lo) && (v <= hi);
    endfunction

    state_e           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             duty_ok;
    logic             rise;

`ifdef CLK_RATIO_DUTY_EN
    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        logic signed [CNT_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    logic             level;
    logic [CNT_W-1:0] tol_q, tol_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] lo_q, lo_d;
    logic             seen_q, seen_d;
    logic             derr_q, derr_d;
`endif

    clk_ratio_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .mon_i   (bus.mon_in),
`ifdef CLK_RATIO_DUTY_EN
        .level_o (level),
`endif
        .rise_o  (rise)
    );

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        min_d      = min_q;
        max_d      = max_q;
        cnt_d      = cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        duty_ok    = 1'b1;
`ifdef CLK_RATIO_DUTY_EN
        tol_d  = tol_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        seen_d = seen_q;
        derr_d = derr_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    win_d  = bus.win_len;
                    min_d  = bus.exp_min;
                    max_d  = bus.exp_max;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    pass_d = 1'b0;
                    busy_d = 1'b1;
`ifdef CLK_RATIO_DUTY_EN
                    tol_d  = bus.duty_tol;
                    hi_d   = '0;
                    lo_d   = '0;
                    seen_d = 1'b0;
                    derr_d = 1'b0;
`endif
                    state_d = (bus.win_len != '0) ? MEASURE : REPORT;
                end
            end
            MEASURE: begin
                win_d = win_q - WIN_W'(1);
                if (rise) begin
                    if (&cnt_q) ovf_d = 1'b1;
                    else        cnt_d = sat_inc(cnt_q);
                end
`ifdef CLK_RATIO_DUTY_EN
                // Run lengths are only meaningful once a full period has been framed by two rises.
                if (rise) begin
                    if (seen_q && (abs_diff(hi_q, lo_q) > {1'b0, tol_q})) derr_d = 1'b1;
                    hi_d   = CNT_W'(1);
                    lo_d   = '0;
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    if (level) hi_d = sat_inc(hi_q);
                    else       lo_d = sat_inc(lo_q);
                end
`endif
                if (win_q == WIN_W'(1)) state_d = REPORT;
            end
            REPORT: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef CLK_RATIO_DUTY_EN
        duty_ok = !derr_d;
`endif
        // Results are registered on entry to REPORT so they are valid alongside done.
        if ((state_d == REPORT) && (state_q != REPORT)) begin
            done_d     = 1'b1;
            edge_cnt_d = cnt_d;
            pass_d     = in_range(cnt_d, min_d, max_d) && !ovf_d && duty_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef CLK_RATIO_DUTY_EN
            hi_q       <= '0;
            lo_q       <= '0;
            seen_q     <= 1'b0;
            derr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
`ifdef CLK_RATIO_DUTY_EN
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            seen_q     <= seen_d;
            derr_q     <= derr_d;
`endif
        end
    end

    // Settings latched on start; they are only read after being loaded.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        min_q <= min_d;
        max_q <= max_d;
`ifdef CLK_RATIO_DUTY_EN
        tol_q <= tol_d;
`endif
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.edge_cnt = edge_cnt_q;
    assign bus.overflow = ovf_q;
`ifdef CLK_RATIO_DUTY_EN
    assign bus.duty_err = derr_q;
`endif

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Bench for clk_ratio_monitor: window-level edge-count model plus directed scenarios.
`timescale 1ns/1ps
module tb_clk_ratio_monitor;
    localparam int CW  = 16;
    localparam int WW  = 16;
    localparam int SS  = 2;
    localparam int CW4 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic mon   = 1'b0;
    always #5 clk = ~clk;

    clk_ratio_monitor_if #(.CNT_W(CW),  .WIN_W(WW)) bus  ();
    clk_ratio_monitor_if #(.CNT_W(CW4), .WIN_W(WW)) bus4 ();
    assign bus.mon_in  = mon;
    assign bus4.mon_in = mon;

    clk_ratio_monitor #(.CNT_W(CW), .WIN_W(WW), .SYNC_STAGES(SS)) dut (
        .clk (clk), .rst_n (rst_n), .bus (bus)
    );
    clk_ratio_monitor #(.CNT_W(CW4), .WIN_W(WW), .SYNC_STAGES(SS)) dut4 (
        .clk (clk), .rst_n (rst_n), .bus (bus4)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Pattern generator: pat_hi cycles high, pat_lo low; pat_hi=0 holds mon low.
    int pat_hi = 0;
    int pat_lo = 1;
    int phase  = 0;
    always @(negedge clk) begin
        if (pat_hi == 0) mon = 1'b0;
        else begin
            mon   = (phase < pat_hi);
            phase = (phase + 1) % (pat_hi + pat_lo);
        end
    end

    // History of mon as seen at each clk edge (0 while in reset).
    int cyc = 0;
    bit hist [int];

    function automatic bit s(input int j);
        return (j >= 1 && hist.exists(j)) ? hist[j] : 1'b0;
    endfunction

    // Window model: rises of the delayed signal inside the window's cycles.
    function automatic void model(input int acc, input int w, input int maxc,
                                  input int emin, input int emax, input int tol,
                                  output int cnt, output bit ovf, output bit derr,
                                  output bit pass);
        int rises[$];
        int hi, lo, d;
        cnt = 0; ovf = 1'b0; derr = 1'b0;
        for (int k = acc; k < acc + w; k++) begin
            if (s(k - SS + 1) && !s(k - SS)) begin
                rises.push_back(k);
                if (cnt == maxc) ovf = 1'b1;
                else             cnt++;
            end
        end
        for (int i = 0; i + 1 < rises.size(); i++) begin
            hi = 0; lo = 0;
            for (int k = rises[i]; k < rises[i+1]; k++) begin
                if (s(k - SS + 1)) hi++;
                else               lo++;
            end
            d = (hi > lo) ? hi - lo : lo - hi;
            if (d > tol) derr = 1'b1;
        end
        pass = (emin <= emax) && (cnt >= emin) && (cnt <= emax) && !ovf;
`ifdef CLK_RATIO_DUTY_EN
        pass = pass && !derr;
`endif
    endfunction

    // Transaction model of the main DUT: accept edge, window, latched bounds.
    bit m_act = 1'b0;
    int m_acc = 0, m_w = 0, m_min = 0, m_max = 0, m_tol = 0;

    always @(posedge clk) begin
        cyc++;
        hist[cyc] = rst_n ? mon : 1'b0;
        if (!rst_n) m_act = 1'b0;
        else if (m_act) begin
            if (cyc == m_acc + m_w + 1) m_act = 1'b0;
        end else if (bus.start) begin
            m_act = 1'b1;
            m_acc = cyc;
            m_w   = int'(bus.win_len);
            m_min = int'(bus.exp_min);
            m_max = int'(bus.exp_max);
`ifdef CLK_RATIO_DUTY_EN
            m_tol = int'(bus.duty_tol);
`endif
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit exp_done, e_ovf, e_derr, e_pass;
        int e_cnt;
        if (!rst_n) begin
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_done", 32'(bus.done), 0);
            chk("rst_pass", 32'(bus.pass), 0);
            chk("rst_edge_cnt", 32'(bus.edge_cnt), 0);
            chk("rst_overflow", 32'(bus.overflow), 0);
        end else begin
            exp_done = m_act && (cyc == m_acc + m_w);
            chk("busy", 32'(bus.busy), 32'(m_act));
            chk("done", 32'(bus.done), 32'(exp_done));
            if (exp_done) begin
                model(m_acc, m_w, (1 << CW) - 1, m_min, m_max, m_tol, e_cnt, e_ovf, e_derr, e_pass);
                chk("edge_cnt", 32'(bus.edge_cnt), e_cnt);
                chk("overflow", 32'(bus.overflow), 32'(e_ovf));
                chk("pass", 32'(bus.pass), 32'(e_pass));
`ifdef CLK_RATIO_DUTY_EN
                chk("duty_err", 32'(bus.duty_err), 32'(e_derr));
`endif
            end
        end
    end

    int sc;   // cycle in which start was driven
    int dc;   // cycle in which done was seen

    task automatic do_start(input int w, input int emin, input int emax, input int tol);
        @(negedge clk);
        bus.win_len = WW'(w);
        bus.exp_min = CW'(emin);
        bus.exp_max = CW'(emax);
`ifdef CLK_RATIO_DUTY_EN
        bus.duty_tol = CW'(tol);
`endif
        bus.start = 1'b1;
        sc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n;
        n = 0;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done within %0d", nm, budget);
        end
        dc = cyc;
    endtask

    task automatic pulse_reset(input int hold);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (hold) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, e_cnt;
        bit e_ovf, e_derr, e_pass;
        bus.start = 1'b0; bus.win_len = '0; bus.exp_min = '0; bus.exp_max = '0;
        bus4.start = 1'b0; bus4.win_len = '0; bus4.exp_min = '0; bus4.exp_max = '0;
`ifdef CLK_RATIO_DUTY_EN
        bus.duty_tol = '0;
        bus4.duty_tol = '0;
`endif
        repeat (3) @(negedge clk);
        chk("init_edge_cnt", 32'(bus.edge_cnt), 0);
        chk("init_busy", 32'(bus.busy), 0);
        pulse_reset(1);

        // 4 high / 4 low, window 64, range 7..9
        pat_hi = 4; pat_lo = 4;
        repeat (20) @(negedge clk);
        do_start(64, 7, 9, 0);
        wait_done(100, "t1");
        chk("t1_latency", dc - sc, 65);
        chk("t1_edge_cnt", 32'(bus.edge_cnt), 8);
        chk("t1_pass", 32'(bus.pass), 1);
        @(negedge clk);
        chk("t1_pass_held", 32'(bus.pass), 1);
        chk("t1_busy_low", 32'(bus.busy), 0);

        do_start(64, 10, 12, 0);
        wait_done(100, "t2");
        chk("t2_edge_cnt", 32'(bus.edge_cnt), 8);
        chk("t2_pass", 32'(bus.pass), 0);

        do_start(64, 9, 7, 0);
        wait_done(100, "t2b");
        chk("t2b_pass", 32'(bus.pass), 0);

        // mon held low, zero-length window
        pat_hi = 0;
        repeat (10) @(negedge clk);
        do_start(0, 0, 0, 0);
        wait_done(10, "t3");
        chk("t3_latency", dc - sc, 1);
        chk("t3_edge_cnt", 32'(bus.edge_cnt), 0);
        chk("t3_pass", 32'(bus.pass), 1);

        // Re-pulsed start is ignored; reset mid-window aborts
        pat_hi = 4; pat_lo = 4;
        repeat (10) @(negedge clk);
        do_start(64, 7, 9, 0);
        repeat (8) @(negedge clk);
        bus.win_len = WW'(5);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("t4_busy_mid", 32'(bus.busy), 1);
        while (cyc < sc + 20) @(negedge clk);
        pulse_reset(3);
        nd = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("t4_no_done", nd, 0);
        chk("t4_edge_cnt", 32'(bus.edge_cnt), 0);
        do_start(64, 7, 9, 0);
        wait_done(100, "t4b");
        chk("t4b_latency", dc - sc, 65);
        chk("t4b_edge_cnt", 32'(bus.edge_cnt), 8);
        chk("t4b_pass", 32'(bus.pass), 1);

        // Narrow counter saturates: period 4 over 100 cycles
        pat_hi = 2; pat_lo = 2;
        repeat (10) @(negedge clk);
        @(negedge clk);
        bus4.win_len = WW'(100); bus4.exp_min = '0; bus4.exp_max = CW4'(15);
        bus4.start = 1'b1;
        sc = cyc;
        @(negedge clk);
        bus4.start = 1'b0;
        nd = 0;
        while (!bus4.done && nd < 200) begin
            @(negedge clk);
            nd++;
        end
        chk("t5_latency", cyc - sc, 101);
        chk("t5_edge_cnt", 32'(bus4.edge_cnt), 15);
        chk("t5_overflow", 32'(bus4.overflow), 1);
        chk("t5_pass", 32'(bus4.pass), 0);
        model(sc + 1, 100, 15, 0, 15, 0, e_cnt, e_ovf, e_derr, e_pass);
        chk("t5_model_cnt", 32'(bus4.edge_cnt), e_cnt);
        chk("t5_model_ovf", 32'(bus4.overflow), 32'(e_ovf));

`ifdef CLK_RATIO_DUTY_EN
        // 6 high / 2 low: |6-2|=4
        pat_hi = 6; pat_lo = 2;
        repeat (20) @(negedge clk);
        do_start(64, 7, 9, 2);
        wait_done(100, "t6");
        chk("t6_edge_cnt", 32'(bus.edge_cnt), 8);
        chk("t6_duty_err", 32'(bus.duty_err), 1);
        chk("t6_pass", 32'(bus.pass), 0);
        do_start(64, 7, 9, 4);
        wait_done(100, "t6b");
        chk("t6b_duty_err", 32'(bus.duty_err), 0);
        chk("t6b_pass", 32'(bus.pass), 1);
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
